// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressed little-endian data memory, self-clearing, fixed-latency responses
// Optional per-request trace output when DATA_MEM_TRACE_EN is defined.
module data_memory_sized #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              init_done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = AW - 2;
  localparam int WN = DEPTH / 4;
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic rst_sn;
  logic [31:0] mem_q [WN];
  logic fire, err, wr;
  logic [WW-1:0] wa;
  logic [1:0] off;
  logic [31:0] word, ld, lane;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [3:0] be;
  logic v1_q, e1_q;
  logic [31:0] d1_q;
  // Reset asserts immediately but releases only after two clean edges
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_sn = sync_q[1];
  always_ff @(posedge clk_i or negedge rst_sn)
    if (!rst_sn) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = (state_q == INIT && cnt_q == WW'(WN - 1)) ? RUN : state_q;
    cnt_d   = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    req_ready_o = state_q == RUN;
    init_done_o = state_q == RUN;
  end
  assign fire   = req_valid_i & req_ready_o;
  assign wa     = req_addr_i[AW-1:2];
  assign off    = req_addr_i[1:0];
  assign err    = (req_size_i == 2'b11) | (req_size_i == 2'b01 & off[0]) |
                  (req_size_i == 2'b10 & |off) | (req_addr_i >= ADDR_W'(DEPTH));
  assign word   = mem_q[wa];
  assign byte_v = word[{off, 3'b000} +: 8];
  assign half_v = word[{off[1], 4'b0000} +: 16];
  assign ld     = req_size_i == 2'b00 ? {{24{~req_unsigned_i & byte_v[7]}}, byte_v} :
                  req_size_i == 2'b01 ? {{16{~req_unsigned_i & half_v[15]}}, half_v} : word;
  assign be     = req_size_i == 2'b00 ? 4'b0001 << off :
                  req_size_i == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane   = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
                  req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
  assign wr     = fire & req_we_i & ~err;
  // Load data is taken from the old contents, so same-edge stores never leak into it
  always_ff @(posedge clk_i)
    if (state_q == INIT) mem_q[cnt_q] <= '0;
    else if (wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[wa][8*b +: 8] <= lane[8*b +: 8];
  always_ff @(posedge clk_i or negedge rst_sn)
    if (!rst_sn) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= fire;
      e1_q <= fire & err;
      d1_q <= (fire & ~req_we_i & ~err) ? ld : '0;
    end
  generate
    if (LATENCY == 2) begin : g_lat2
      logic v2_q, e2_q;
      logic [31:0] d2_q;
      always_ff @(posedge clk_i or negedge rst_sn)
        if (!rst_sn) begin
          v2_q <= 1'b0;
          e2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          e2_q <= e1_q;
          d2_q <= d1_q;
        end
      assign resp_valid_o = v2_q;
      assign resp_err_o   = e2_q;
      assign resp_rdata_o = d2_q;
    end else begin : g_lat1
      if (LATENCY != 1) begin : g_bad
        $error("data_memory_sized: LATENCY must be 1 or 2");
      end
      assign resp_valid_o = v1_q;
      assign resp_err_o   = e1_q;
      assign resp_rdata_o = d1_q;
    end
  endgenerate
`ifdef DATA_MEM_TRACE_EN
  always @(posedge clk_i)
    if (fire)
      $display("@%m %0t [0x%0h]%s0x%0h%s", $time, req_addr_i, req_we_i ? "<-" : "->",
               req_we_i ? req_wdata_i : (err ? 32'd0 : ld), err ? " ERR" : "");
`endif
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: random + directed scoreboard bench for LATENCY=1 and LATENCY=2 instances
module tb_data_memory_sized;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic rdy1, rdy2, v1, v2, e1, e2, id1, id2;
  logic [31:0] d1, d2;
  int vectors = 0, errors = 0, cyc = 0;
  typedef struct {int c; logic err; logic [31:0] d;} exp_t;
  exp_t q1[$], q2[$];
  logic [7:0] mdl [256];

  data_memory_sized #(.DEPTH(256), .ADDR_W(32), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(v1), .resp_rdata_o(d1), .resp_err_o(e1), .init_done_o(id1));
  data_memory_sized #(.DEPTH(256), .ADDR_W(32), .LATENCY(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy2), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(v2), .resp_rdata_o(d2), .resp_err_o(e2), .init_done_o(id2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) chk("lat1 unexpected resp", 1, 0);
      else begin
        exp_t x;
        x = q1.pop_front();
        chk("lat1 resp cycle", cyc, x.c);
        chk("lat1 rdata", d1, x.d);
        chk("lat1 err", e1, x.err);
      end
    end else chk("lat1 idle outputs zero", {e1, d1}, 0);
  end

  always @(negedge clk) begin
    if (v2) begin
      if (q2.size() == 0) chk("lat2 unexpected resp", 1, 0);
      else begin
        exp_t x;
        x = q2.pop_front();
        chk("lat2 resp cycle", cyc, x.c);
        chk("lat2 rdata", d2, x.d);
        chk("lat2 err", e2, x.err);
      end
    end else chk("lat2 idle outputs zero", {e2, d2}, 0);
  end

  // Reference: byte array, rules applied directly to the address/size/data
  task automatic do_req(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                        input logic [31:0] wd, input bit use_k = 0, input logic [31:0] kd = 0);
    exp_t x;
    logic [31:0] v;
    logic er;
    int n;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    chk("ready when issuing", {rdy1, rdy2}, 2'b11);
    er = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0) || (a >= 256);
    v = 0;
    if (!er) begin
      n = 1 << sz;
      if (we) for (int i = 0; i < n; i++) mdl[a + i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) v = v | (32'(mdl[a + i]) << (8 * i));
        if (n < 4 && !un && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
      end
    end
    if (use_k) v = kd;
    x.c = cyc + 1; x.err = er; x.d = v;
    q1.push_back(x);
    x.c = cyc + 2;
    q2.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 0; req_we = $urandom; req_size = 2'($urandom); req_addr = $urandom % 256;
    req_wdata = $urandom;
  endtask

  task automatic do_reset();
    int n;
    rst_n = 0; req_valid = 0;
    q1.delete(); q2.delete();
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("reset outputs", {rdy1, id1, v1, e1, d1, rdy2, id2, v2, e2, d2}, 0);
    end
    rst_n = 1;
    // A request held during clearing must never be accepted
    req_valid = 1; req_we = 1; req_size = 2; req_addr = 0; req_wdata = 32'hFFFFFFFF;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (rdy1) break;
      n++;
    end
    chk("init cycles 64..66 (clear + reset sync)", (n >= 64 && n <= 66), 1);
    chk("init_done and lat2 ready rise together", {id1, rdy2, id2}, 3'b111);
    req_valid = 0;
  endtask

  initial begin
    logic [31:0] a, w;
    logic [1:0] sz;
    int r;
    do_reset();
    for (int i = 0; i < 12; i++) do_req(0, 2, 0, 4 * ($urandom % 64), 0, 1, 0);
    do_req(0, 0, 1, 255, 0, 1, 0);
    do_req(1, 2, 0, 32'h10, 32'hDEADBEEF);
    do_req(0, 0, 0, 32'h13, 0, 1, 32'hFFFFFFDE);
    do_req(0, 0, 1, 32'h13, 0, 1, 32'h000000DE);
    do_req(1, 1, 0, 32'h22, 32'hABCD8001);
    do_req(0, 1, 0, 32'h22, 0, 1, 32'hFFFF8001);
    do_req(0, 1, 1, 32'h22, 0, 1, 32'h00008001);
    do_req(0, 2, 1, 32'h20, 0, 1, 32'h80010000);
    do_req(0, 2, 0, 32'h11, 0);
    do_req(0, 1, 0, 32'h21, 0);
    do_req(0, 3, 0, 32'h10, 0);
    do_req(0, 2, 0, 32'h100, 0);
    do_req(1, 2, 0, 32'h11, 32'h11111111);
    do_req(1, 1, 0, 32'h13, 32'h22222222);
    do_req(1, 3, 0, 32'h10, 32'h33333333);
    do_req(1, 0, 0, 32'h110, 32'h44444444);
    do_req(1, 2, 0, 32'h80000010, 32'h55555555);
    do_req(0, 2, 0, 32'h10, 0, 1, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      do_req(1, 2, 0, 32'h40, w);
      do_req(0, 2, 0, 32'h40, 0, 1, w);
    end
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      do_req(1, 0, 0, 32'h45, w);
      do_req(0, 0, 1, 32'h45, 0, 1, {24'h0, w[7:0]});
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 5 == 0) idle();
      else begin
        r = $urandom % 16;
        sz = r < 5 ? 2'd0 : r < 10 ? 2'd1 : r < 15 ? 2'd2 : 2'd3;
        a = $urandom_range(0, 255);
        if ($urandom % 8 != 0 && sz != 3) a = a & ~((32'd1 << sz) - 1);
        if ($urandom % 16 == 0) a = $urandom;
        do_req($urandom % 2, sz, $urandom % 2, a, $urandom);
      end
    end
    do_req(1, 2, 0, 32'h30, 32'h12345678);
    do_req(0, 2, 0, 32'h30, 0);
    @(posedge clk);
    #1;
    do_reset();
    do_req(0, 2, 0, 32'h30, 0, 1, 0);
    do_req(0, 2, 0, 32'h10, 0, 1, 0);
    do_req(0, 0, 0, 32'h13, 0, 1, 0);
    repeat (4) idle();
    chk("lat1 responses outstanding", q1.size(), 0);
    chk("lat2 responses outstanding", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
